// File: rtl/axi_ibuf_loader_if.sv
// AXI4-Stream ingress bundle carrying packed coefficient beats into the loader.
interface axi_ibuf_loader_if;
    logic [511:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    // Stream source (host DMA side)
    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    // Stream sink (loader side)
    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_ibuf_loader.sv
// Ingress loader: turns a 512-bit AXI4-Stream of eight 64-bit coefficient lanes
// into the transposer's sequential write stream. Each load starts with a
// one-cycle transposer reset, numbers beats 0..NUM_BEATS-1 as buffer addresses,
// flags TLAST framing errors, and waits for the transposer's done pulse before
// reporting completion.
module axi_ibuf_loader #(
    parameter int DATA_WIDTH = 39,
    parameter int NUM_BEATS  = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_load_done,
    output logic                    o_err,
    axi_ibuf_loader_if.slave        s_axis,
    output logic                    o_ibuf_reset,
    output logic                    o_ibuf_wren,
    output logic [11:0]             o_ibuf_addr,
    output logic [8*DATA_WIDTH-1:0] o_ibuf_data,
    input  logic                    i_ibuf_done
);

    localparam logic [11:0] LAST_BEAT = 12'(NUM_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                    state_q;
    logic [11:0]               cnt_q;
    logic                      busy_q;
    logic                      load_done_q;
    logic                      err_q;
    logic                      tready_q;
    logic                      ibuf_reset_q;
    logic                      wren_q;
    logic [11:0]               addr_q;
    logic [8*DATA_WIDTH-1:0]   data_q;
    logic [8*DATA_WIDTH-1:0]   data_d;
    logic                      hs_s;

    // Keep the low DATA_WIDTH bits of each 64-bit lane and pack lanes densely.
    function automatic logic [8*DATA_WIDTH-1:0] pack_lanes(input logic [511:0] beat);
        logic [8*DATA_WIDTH-1:0] packed_v;
        packed_v = '0;
        for (int k = 0; k < 8; k++) begin
            packed_v[k*DATA_WIDTH +: DATA_WIDTH] = beat[k*64 +: DATA_WIDTH];
        end
        return packed_v;
    endfunction

    // Handshake and truncated beat data feeding the write-path registers.
    always_comb begin
        hs_s   = s_axis.tvalid & tready_q;
        data_d = pack_lanes(s_axis.tdata);
    end

    // Load sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 12'd0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
            tready_q     <= 1'b0;
            ibuf_reset_q <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= 12'd0;
            data_q       <= '0;
        end else begin
            // Single-cycle strobes default low every cycle.
            ibuf_reset_q <= 1'b0;
            wren_q       <= 1'b0;
            load_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q      <= ST_CLR;
                        busy_q       <= 1'b1;
                        ibuf_reset_q <= 1'b1;
                        err_q        <= 1'b0;
                    end
                end
                ST_CLR: begin
                    state_q  <= ST_LOAD;
                    cnt_q    <= 12'd0;
                    err_q    <= 1'b0;
                    tready_q <= 1'b1;
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        wren_q <= 1'b1;
                        addr_q <= cnt_q;
                        data_q <= data_d;
                        if (cnt_q == LAST_BEAT) begin
                            // The beat count, not TLAST, ends the load.
                            state_q  <= ST_WAIT;
                            tready_q <= 1'b0;
                            if (!s_axis.tlast) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 12'd1;
                            if (s_axis.tlast) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_ibuf_done) begin
                        state_q     <= ST_DONE;
                        load_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = busy_q;
    assign o_load_done   = load_done_q;
    assign o_err         = err_q;
    assign s_axis.tready = tready_q;
    assign o_ibuf_reset  = ibuf_reset_q;
    assign o_ibuf_wren   = wren_q;
    assign o_ibuf_addr   = addr_q;
    assign o_ibuf_data   = data_q;

endmodule

// File: tb/tb_axi_ibuf_loader.sv
// Directed-plus-random bench for axi_ibuf_loader: drives whole loads with
// randomised lane data and tvalid gaps, and checks every cycle against
// expectations computed from the load rules (beat index, masked lanes,
// framing flag, handshake timing).
module tb_axi_ibuf_loader;

    localparam int DW = 39;
    localparam int NB = 2048;

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic            i_ibuf_done;
    logic            o_busy;
    logic            o_load_done;
    logic            o_err;
    logic            o_ibuf_reset;
    logic            o_ibuf_wren;
    logic [11:0]     o_ibuf_addr;
    logic [8*DW-1:0] o_ibuf_data;

    int compared;
    int mismatched;
    int rst_pulses;

    axi_ibuf_loader_if ifc ();

    axi_ibuf_loader #(.DATA_WIDTH(DW), .NUM_BEATS(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_load_done  (o_load_done),
        .o_err        (o_err),
        .s_axis       (ifc),
        .o_ibuf_reset (o_ibuf_reset),
        .o_ibuf_wren  (o_ibuf_wren),
        .o_ibuf_addr  (o_ibuf_addr),
        .o_ibuf_data  (o_ibuf_data),
        .i_ibuf_done  (i_ibuf_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which the transposer reset is high.
    always @(negedge clk) begin
        if (o_ibuf_reset === 1'b1) rst_pulses++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference packing: each lane masked to DW bits, placed at lane*DW.
    function automatic logic [8*DW-1:0] model_pack(input logic [511:0] td);
        logic [8*DW-1:0] r;
        logic [63:0]     mask;
        logic [63:0]     lane;
        r    = '0;
        mask = (64'd1 << DW) - 64'd1;
        for (int k = 0; k < 8; k++) begin
            lane = td[k*64 +: 64] & mask;
            r    = r | ((8*DW)'(lane) << (k*DW));
        end
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   512'(o_busy),        512'd0);
        chk({tag, "_done"},   512'(o_load_done),   512'd0);
        chk({tag, "_err"},    512'(o_err),         512'd0);
        chk({tag, "_tready"}, 512'(ifc.tready),    512'd0);
        chk({tag, "_ireset"}, 512'(o_ibuf_reset),  512'd0);
        chk({tag, "_wren"},   512'(o_ibuf_wren),   512'd0);
        chk({tag, "_addr"},   512'(o_ibuf_addr),   512'd0);
        chk({tag, "_data"},   512'(o_ibuf_data),   512'd0);
    endtask

    // One complete load. gap: percent idle cycles; early: beat with stray
    // tlast (-1 none); omit_last: drop tlast on final beat; start_at/done_at:
    // beat at which spurious i_start/i_ibuf_done are driven (-1 none);
    // abort_at: beat after which rst_n is pulsed (-1 none).
    task automatic run_load(input int gap, input int early, input bit omit_last,
                            input int start_at, input int done_at,
                            input int abort_at, input bit start_in_wait);
        int          b;
        int          cyc;
        int          rc0;
        bit          v;
        bit          exp_err;
        logic [511:0] td;
        rc0 = rst_pulses;
        i_start = 1'b1;
        tick();
        chk("start_ireset", 512'(o_ibuf_reset), 512'd1);
        chk("start_busy",   512'(o_busy),       512'd1);
        chk("start_tready", 512'(ifc.tready),   512'd0);
        i_start = 1'b0;
        tick();
        chk("clr_ireset", 512'(o_ibuf_reset), 512'd0);
        chk("clr_tready", 512'(ifc.tready),   512'd1);
        chk("clr_err",    512'(o_err),        512'd0);
        exp_err = 1'b0;
        b   = 0;
        cyc = 0;
        while (b < NB && cyc < 40000) begin
            cyc++;
            v = ($urandom_range(99) >= gap);
            for (int k = 0; k < 8; k++) begin
                td[k*64 +: 64] = {$urandom(), 16'($urandom()), 12'(b), 4'(k)};
            end
            ifc.tdata   = td;
            ifc.tvalid  = v;
            ifc.tlast   = v && ((b == early) || (b == NB - 1 && !omit_last));
            i_start     = (b == start_at);
            i_ibuf_done = (b == done_at) || (done_at >= 0 && b == NB - 1);
            chk("load_tready", 512'(ifc.tready), 512'd1);
            tick();
            if (v) begin
                chk("wr_wren", 512'(o_ibuf_wren), 512'd1);
                chk("wr_addr", 512'(o_ibuf_addr), 512'(b));
                chk("wr_data", 512'(o_ibuf_data), 512'(model_pack(td)));
                if ((b == NB - 1) ? !ifc.tlast : ifc.tlast) exp_err = 1'b1;
                if (b == abort_at) begin
                    ifc.tvalid  = 1'b0;
                    ifc.tlast   = 1'b0;
                    i_start     = 1'b0;
                    i_ibuf_done = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 chk_all_zero("abort");
                    tick();
                    chk_all_zero("abort_hold");
                    rst_n = 1'b1;
                    tick();
                    chk("abort_idle_busy", 512'(o_busy), 512'd0);
                    return;
                end
                b++;
            end else begin
                chk("gap_wren", 512'(o_ibuf_wren), 512'd0);
            end
        end
        if (b < NB) chk("load_timeout", 512'(b), 512'(NB));
        ifc.tvalid  = 1'b0;
        ifc.tlast   = 1'b0;
        i_start     = 1'b0;
        i_ibuf_done = 1'b0;
        chk("final_tready", 512'(ifc.tready), 512'd0);
        chk("final_busy",   512'(o_busy),     512'd1);
        chk("final_err",    512'(o_err),      512'(exp_err));
        for (int w = 0; w < 3; w++) begin
            i_start = start_in_wait;
            tick();
            chk("wait_done",   512'(o_load_done),  512'd0);
            chk("wait_busy",   512'(o_busy),       512'd1);
            chk("wait_wren",   512'(o_ibuf_wren),  512'd0);
            chk("wait_ireset", 512'(o_ibuf_reset), 512'd0);
        end
        i_start     = 1'b0;
        i_ibuf_done = 1'b1;
        tick();
        i_ibuf_done = 1'b0;
        chk("done_pulse", 512'(o_load_done), 512'd1);
        chk("done_busy",  512'(o_busy),      512'd1);
        tick();
        chk("done_clear", 512'(o_load_done), 512'd0);
        chk("idle_busy",  512'(o_busy),      512'd0);
        chk("idle_err",   512'(o_err),       512'(exp_err));
        chk("ireset_count", 512'(rst_pulses - rc0), 512'd1);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_pulses  = 0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_ibuf_done = 1'b0;
        ifc.tdata   = '0;
        ifc.tvalid  = 1'b0;
        ifc.tlast   = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Full back-to-back load with correct framing.
        run_load(0, -1, 1'b0, -1, -1, -1, 1'b0);
        // Same load with roughly 30% idle cycles.
        run_load(30, -1, 1'b0, -1, -1, -1, 1'b0);
        // Stray tlast on beat 100; next load must clear the flag.
        run_load(0, 100, 1'b0, -1, -1, -1, 1'b0);
        // Missing tlast on the final beat.
        run_load(10, -1, 1'b1, -1, -1, -1, 1'b0);
        // Spurious start during LOAD and WAIT, spurious done during LOAD
        // and on the final handshake.
        run_load(15, -1, 1'b0, 200, 700, -1, 1'b1);
        // Reset mid-load after beat 500, then a clean reload from address 0.
        run_load(20, -1, 1'b0, -1, -1, 500, 1'b0);
        run_load(0, -1, 1'b0, -1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
